// File: rtl/uart_mem_loader_if.sv
// Main-memory write port shared by the boot loader and the pipeline.
// The loader drives it through the master modport; memory or the write mux uses the slave modport.
interface uart_mem_loader_if;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;

  modport master (output mem_write, output mem_wmask, output mem_wdata, output mem_addr);
  modport slave  (input  mem_write, input  mem_wmask, input  mem_wdata, input  mem_addr);
endinterface

// File: rtl/uart_mem_loader.sv
// UART boot loader: receives 'L' packets and writes their words to memory while holding the CPU.
// A 'G' byte releases the CPU. Every command is acknowledged with one byte on tx.
module uart_mem_loader #(
  parameter int CLOCK_RATE = 12_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  output logic cpu_hold,
  output logic busy,
  uart_mem_loader_if.master mem
);
  localparam int DIV  = CLOCK_RATE / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_ACK, S_RUN} state_t;

  rx_state_t   rx_st;
  logic        rx_s1, rx_s2, rx_d;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_sh;
  logic        rx_valid, rx_err;

  logic        tx_busy, tx_load;
  logic [7:0]  tx_data;
  logic [8:0]  tx_sh;
  logic [3:0]  tx_bits;
  logic [CW-1:0] tx_cnt;

  state_t      state;
  logic [1:0]  bcnt;
  logic [31:0] addr;
  logic [15:0] count;
  logic [23:0] wbuf;
  logic [7:0]  ack_code;
  logic        ack_run;

  // Receiver: rx_valid/rx_err pulse one cycle after the stop-bit sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_st    <= R_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (rx_st)
        R_IDLE: if (rx_d && !rx_s2) begin
          rx_st  <= R_START;
          rx_cnt <= '0;
        end
        R_START: if (rx_cnt == CW'(HALF - 1)) begin
          rx_cnt  <= '0;
          rx_bits <= '0;
          rx_st   <= rx_s2 ? R_IDLE : R_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        R_DATA: if (rx_cnt == CW'(DIV - 1)) begin
          rx_cnt  <= '0;
          rx_sh   <= {rx_s2, rx_sh[7:1]};
          rx_bits <= rx_bits + 1'b1;
          if (rx_bits == 3'd7) rx_st <= R_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        R_STOP: if (rx_cnt == CW'(DIV - 1)) begin
          rx_cnt   <= '0;
          rx_valid <= rx_s2;
          rx_err   <= !rx_s2;
          rx_st    <= R_IDLE;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // Transmitter: the start bit goes out on load, then 8 data bits and the stop bit from tx_sh.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_sh   <= '1;
      tx_bits <= '0;
      tx_cnt  <= '0;
    end else if (tx_load) begin
      tx      <= 1'b0;
      tx_sh   <= {1'b1, tx_data};
      tx_bits <= 4'd9;
      tx_cnt  <= '0;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == CW'(DIV - 1)) begin
        tx_cnt <= '0;
        if (tx_bits == 4'd0) tx_busy <= 1'b0;
        else begin
          tx      <= tx_sh[0];
          tx_sh   <= {1'b1, tx_sh[8:1]};
          tx_bits <= tx_bits - 1'b1;
        end
      end else tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign busy = (state != S_IDLE) && (state != S_RUN);

  // Command FSM. In DATA, the cycle after a write strobe advances addr and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bcnt          <= '0;
      addr          <= '0;
      count         <= '0;
      wbuf          <= '0;
      ack_code      <= '0;
      ack_run       <= 1'b0;
      tx_load       <= 1'b0;
      tx_data       <= '0;
      cpu_hold      <= 1'b1;
      mem.mem_write <= 1'b0;
      mem.mem_wmask <= '0;
      mem.mem_wdata <= '0;
      mem.mem_addr  <= '0;
    end else begin
      mem.mem_write <= 1'b0;
      mem.mem_wmask <= '0;
      tx_load       <= 1'b0;
      if (rx_err && (state == S_IDLE || state == S_ADDR || state == S_LEN || state == S_DATA)) begin
        state    <= S_ACK;
        ack_code <= 8'h21;
        ack_run  <= 1'b0;
        bcnt     <= '0;
      end else begin
        case (state)
          S_IDLE: if (rx_valid) begin
            bcnt <= '0;
            if (rx_sh == 8'h4C) state <= S_ADDR;
            else begin
              state    <= S_ACK;
              ack_code <= (rx_sh == 8'h47) ? 8'h4B : 8'h3F;
              ack_run  <= (rx_sh == 8'h47);
            end
          end
          S_ADDR: if (rx_valid) begin
            bcnt <= bcnt + 1'b1;
            if (bcnt == 2'd3) begin
              addr  <= {rx_sh, addr[31:10], 2'b00};
              state <= S_LEN;
              bcnt  <= '0;
            end else addr <= {rx_sh, addr[31:8]};
          end
          S_LEN: if (rx_valid) begin
            count <= {rx_sh, count[15:8]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 2'd1) begin
              bcnt <= '0;
              if ({rx_sh, count[15:8]} == 16'd0) begin
                state    <= S_ACK;
                ack_code <= 8'h4B;
                ack_run  <= 1'b0;
              end else state <= S_DATA;
            end
          end
          S_DATA: if (mem.mem_write) begin
            addr  <= addr + 32'd4;
            count <= count - 1'b1;
            if (count == 16'd1) begin
              state    <= S_ACK;
              ack_code <= 8'h4B;
              ack_run  <= 1'b0;
            end
          end else if (rx_valid) begin
            wbuf <= {rx_sh, wbuf[23:8]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 2'd3) begin
              mem.mem_write <= 1'b1;
              mem.mem_wmask <= 4'hF;
              mem.mem_addr  <= addr;
              mem.mem_wdata <= {rx_sh, wbuf};
            end
          end
          S_ACK: if (!tx_busy) begin
            tx_load <= 1'b1;
            tx_data <= ack_code;
            if (ack_run) begin
              cpu_hold <= 1'b0;
              state    <= S_RUN;
            end else state <= S_IDLE;
          end
          S_RUN: state <= S_RUN;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader at DIV=16: expected writes and ack bytes are queued
// as stimulus is driven and are consumed by the write and tx monitors.
module tb_uart_mem_loader;
  localparam int DIV = 16;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx, cpu_hold, busy;
  uart_mem_loader_if mem_if();

  uart_mem_loader #(.CLOCK_RATE(16), .BAUD_RATE(1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .cpu_hold(cpu_hold), .busy(busy), .mem(mem_if)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [7:0]  txq[$];
  logic        tx_active = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (mem_if.mem_write) begin
      check("wr_expected", 32'(wq_addr.size() != 0), 32'd1);
      if (wq_addr.size() != 0) begin
        check("wr_addr", mem_if.mem_addr, wq_addr.pop_front());
        check("wr_data", mem_if.mem_wdata, wq_data.pop_front());
        check("wr_mask", 32'(mem_if.mem_wmask), 32'hF);
      end
    end
  end

  // TX monitor: samples mid-bit, starting DIV/2 after the falling edge
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && !rst) begin
        tx_active = 1'b1;
        repeat (DIV / 2 - 1) @(negedge clk);
        check("tx_start", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        check("tx_stop", 32'(tx), 32'd1);
        check("tx_expected", 32'(txq.size() != 0), 32'd1);
        if (txq.size() != 0) check("tx_byte", 32'(b), 32'(txq.pop_front()));
        tx_active = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk) rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_seq(input bq_t q);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wq_addr.push_back(a);
    wq_data.push_back(d);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && (txq.size() != 0 || wq_addr.size() != 0 || tx_active); i++)
      @(negedge clk);
    repeat (50) @(negedge clk);
    check({tag, "_tx_left"}, 32'(txq.size()), 32'd0);
    check({tag, "_wr_left"}, 32'(wq_addr.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"},    32'(tx), 32'd1);
    check({tag, "_write"}, 32'(mem_if.mem_write), 32'd0);
    check({tag, "_wmask"}, 32'(mem_if.mem_wmask), 32'd0);
    check({tag, "_wdata"}, mem_if.mem_wdata, 32'd0);
    check({tag, "_addr"},  mem_if.mem_addr, 32'd0);
    check({tag, "_hold"},  32'(cpu_hold), 32'd1);
    check({tag, "_busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst0");

    // Two-word load
    send_byte(8'h4C);
    check("s1_busy", 32'(busy), 32'd1);
    send_seq('{8'h00, 8'h01, 8'h02, 8'h00, 8'h02, 8'h00});
    push_wr(32'h0002_0100, 32'h1234_5678);
    send_seq('{8'h78, 8'h56, 8'h34, 8'h12});
    push_wr(32'h0002_0104, 32'hDEAD_BEEF);
    txq.push_back(8'h4B);
    send_seq('{8'hEF, 8'hBE, 8'hAD, 8'hDE});
    drain("s1");
    check("s1_hold", 32'(cpu_hold), 32'd1);
    check("s1_busy_end", 32'(busy), 32'd0);
    check("s1_addr_hold", mem_if.mem_addr, 32'h0002_0104);
    check("s1_data_hold", mem_if.mem_wdata, 32'hDEAD_BEEF);
    check("s1_wmask_idle", 32'(mem_if.mem_wmask), 32'd0);

    // Zero-length load
    do_reset();
    txq.push_back(8'h4B);
    send_seq('{8'h4C, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    drain("s2");
    check("s2_busy", 32'(busy), 32'd0);

    // Go: release the CPU, then everything is ignored
    do_reset();
    txq.push_back(8'h4B);
    send_byte(8'h47);
    drain("s3");
    check("s3_hold", 32'(cpu_hold), 32'd0);
    send_seq('{8'h4C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    drain("s3_run");
    check("s3_hold_run", 32'(cpu_hold), 32'd0);
    check("s3_busy_run", 32'(busy), 32'd0);

    // Framing error in DATA, then a normal packet
    do_reset();
    send_seq('{8'h4C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00});
    txq.push_back(8'h21);
    send_byte(8'hAA, 1'b0);
    drain("s4_err");
    push_wr(32'h0000_0010, 32'h0102_0304);
    txq.push_back(8'h4B);
    send_seq('{8'h4C, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01});
    drain("s4_ok");

    // Unknown command byte and an rx glitch
    do_reset();
    txq.push_back(8'h3F);
    send_byte(8'h55);
    drain("s5_cmd");
    @(negedge clk) rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    drain("s5_glitch");
    check("s5_busy", 32'(busy), 32'd0);

    // Address wrap
    do_reset();
    push_wr(32'hFFFF_FFFC, 32'h1111_1111);
    push_wr(32'h0000_0000, 32'h2222_2222);
    txq.push_back(8'h4B);
    send_seq('{8'h4C, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00,
               8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22});
    drain("s6_wrap");

    // Reset mid-packet after two data bytes
    send_seq('{8'h4C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h99, 8'h88});
    check("s6_busy_mid", 32'(busy), 32'd1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("s6_rst");
    rst = 1'b0;
    repeat (300) @(negedge clk);
    drain("s6_after");
    check("s6_hold_end", 32'(cpu_hold), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
